// File: rtl/dial_cmd_sequencer.sv
// Buffers host rotation commands and issues them to the dial, spacing issues by each command's step time.
// Optional `DIAL_SEQ_BUSY_EN adds dial_busy; the WAIT timer then counts settle cycles only while the dial is not busy.
module dial_cmd_sequencer #(
  parameter int COUNT_WIDTH   = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
`ifdef DIAL_SEQ_BUSY_EN
  input  logic                            dial_busy,
`endif
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_direction,
  input  logic [COUNT_WIDTH-1:0]          cmd_count,
  output logic                            dial_direction,
  output logic [COUNT_WIDTH-1:0]          dial_count,
  output logic                            dial_valid,
  output logic                            idle,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     issued_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int TMR_W   = COUNT_WIDTH + 1;
  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FIRE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [SETUP_W-1:0]     setup_q, setup_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   dir_q, dir_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dial_valid_q, dial_valid_d;
  logic                   idle_q, idle_d;
  logic [15:0]            issued_q, issued_d;

  logic                   full, empty, push, pop, wait_done;
  logic [TMR_W-1:0]       wait_load;

  always_comb begin
    full  = (level_q == LVL_W'(FIFO_DEPTH));
    empty = (level_q == '0);
    push  = cmd_valid && !full;
    pop   = 1'b0;

`ifdef DIAL_SEQ_BUSY_EN
    wait_load = TMR_W'(SETTLE_CYCLES);
    wait_done = !dial_busy && (timer_q <= TMR_W'(1));
`else
    // One extra bit keeps count + settle from wrapping at the maximum count.
    wait_load = TMR_W'(cnt_q) + TMR_W'(SETTLE_CYCLES);
    wait_done = (timer_q <= TMR_W'(1));
`endif

    state_d  = state_q;
    setup_d  = setup_q;
    timer_d  = timer_q;
    issued_d = issued_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          setup_d = SETUP_W'(SETUP_CYCLES);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        setup_d = setup_q - SETUP_W'(1);
        if (setup_q <= SETUP_W'(1)) begin
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        issued_d = issued_q + 16'd1;
        timer_d  = wait_load;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
`ifdef DIAL_SEQ_BUSY_EN
        if (!dial_busy && timer_q != '0) timer_d = timer_q - TMR_W'(1);
`else
        if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
`endif
        if (wait_done) begin
          // Chain straight into the next command when one is buffered.
          if (!empty) begin
            pop     = 1'b1;
            setup_d = SETUP_W'(SETUP_CYCLES);
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    dir_d = dir_q;
    cnt_d = cnt_q;
    if (pop) begin
      {dir_d, cnt_d} = mem[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    dial_valid_d = (state_d == S_FIRE);
    idle_d       = (state_q == S_IDLE) && empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      setup_q      <= '0;
      timer_q      <= '0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      dial_valid_q <= 1'b0;
      idle_q       <= 1'b1;
      issued_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      setup_q      <= setup_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      dial_valid_q <= dial_valid_d;
      idle_q       <= idle_d;
      issued_q     <= issued_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_direction, cmd_count};
    end
  end

  assign cmd_ready      = !full;
  assign dial_direction = dir_q;
  assign dial_count     = cnt_q;
  assign dial_valid     = dial_valid_q;
  assign idle           = idle_q;
  assign fifo_level     = level_q;
  assign issued_count   = issued_q;

endmodule

// File: tb/tb_dial_cmd_sequencer.sv
// Directed bench for dial_cmd_sequencer with default parameters; issue times are logged by edge number.
module tb_dial_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_direction;
  logic [9:0] cmd_count;
  logic       dial_direction;
  logic [9:0] dial_count;
  logic       dial_valid;
  logic       idle;
  logic [2:0] fifo_level;
  logic [15:0] issued_count;
`ifdef DIAL_SEQ_BUSY_EN
  logic       dial_busy;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int   vt[$];
  logic vd[$];
  int   vc[$];

  dial_cmd_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DIAL_SEQ_BUSY_EN
    .dial_busy      (dial_busy),
`endif
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_direction  (cmd_direction),
    .cmd_count      (cmd_count),
    .dial_direction (dial_direction),
    .dial_count     (dial_count),
    .dial_valid     (dial_valid),
    .idle           (idle),
    .fifo_level     (fifo_level),
    .issued_count   (issued_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // A pulse recorded with edge k was high between edges k and k+1.
  always @(negedge clk) begin
    if (dial_valid === 1'b1) begin
      vt.push_back(cyc);
      vd.push_back(dial_direction);
      vc.push_back(int'(dial_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    vt.delete();
    vd.delete();
    vc.delete();
  endtask

  task automatic push(input logic d, input int c, output int n);
    int w;
    cmd_valid     = 1'b1;
    cmd_direction = d;
    cmd_count     = 10'(c);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 2000) begin
      tick();
      w++;
    end
    if (w >= 2000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    n = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    repeat (3) tick();
    w = 0;
    while (!(idle === 1'b1 && fifo_level == 3'd0) && w < bound) begin
      tick();
      w++;
    end
    checks++;
    if (w >= bound) begin
      errors++;
      $display("FAIL idle_timeout: idle=%b level=%0d required idle=1 level=0", idle, fifo_level);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_direction = 1'b0;
    cmd_count = '0;
    repeat (2) tick();
    checks++; if (dial_valid !== 1'b0) begin errors++; $display("FAIL rst_dial_valid: got %b want 0", dial_valid); end
    checks++; if (dial_direction !== 1'b0) begin errors++; $display("FAIL rst_dial_direction: got %b want 0", dial_direction); end
    checks++; if (dial_count !== 10'd0) begin errors++; $display("FAIL rst_dial_count: got %0d want 0", dial_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_fifo_level: got %0d want 0", fifo_level); end
    checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL rst_issued: got %0d want 0", issued_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n0, n1;
    clear_log();
    push(1'b1, 5, n0);
    push(1'b0, 3, n1);
    checks++; if (n1 !== n0 + 1) begin errors++; $display("FAIL single_accept2: edge %0d want %0d", n1, n0 + 1); end
    checks++; if (dial_count !== 10'd5) begin errors++; $display("FAIL single_load_count: got %0d want 5", dial_count); end
    checks++; if (dial_direction !== 1'b1) begin errors++; $display("FAIL single_load_dir: got %b want 1", dial_direction); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_push_pop_level: got %0d want 1", fifo_level); end
    repeat (3) tick();
    checks++; if (dial_count !== 10'd5 || dial_valid !== 1'b0) begin
      errors++; $display("FAIL single_hold_in_wait: count=%0d valid=%b want 5/0", dial_count, dial_valid);
    end
    wait_idle(100);
    checks++; if (vt.size() != 2) begin errors++; $display("FAIL single_pulses: got %0d want 2", vt.size()); end
    if (vt.size() == 2) begin
      checks++; if (vt[0] != n0 + 2) begin errors++; $display("FAIL single_t0: edge %0d want %0d", vt[0], n0 + 2); end
      checks++; if (vt[1] != n0 + 11) begin errors++; $display("FAIL single_t1: edge %0d want %0d", vt[1], n0 + 11); end
      checks++; if (vd[0] !== 1'b1 || vc[0] != 5) begin errors++; $display("FAIL single_op0: %b,%0d want 1,5", vd[0], vc[0]); end
      checks++; if (vd[1] !== 1'b0 || vc[1] != 3) begin errors++; $display("FAIL single_op1: %b,%0d want 0,3", vd[1], vc[1]); end
    end
    checks++; if (issued_count !== 16'd2) begin errors++; $display("FAIL single_issued: got %0d want 2", issued_count); end
  endtask

  task automatic test_back_to_back();
    int na, nf, tmp, p;
    int exp_t[6];
    logic exp_d[6];
    int exp_c[6];
    clear_log();
    push(1'b1, 1000, na);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) push(logic'(i & 1), i, tmp);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level: got %0d want 4", fifo_level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", cmd_ready); end
    push(1'b0, 4, nf);
    p = na + 1005;
    checks++; if (nf != p + 1) begin errors++; $display("FAIL b2b_fifth_accept: edge %0d want %0d", nf, p + 1); end
    wait_idle(200);
    exp_t = '{na + 2, p + 1, p + 5, p + 10, p + 16, p + 23};
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_c = '{1000, 0, 1, 2, 3, 4};
    checks++; if (vt.size() != 6) begin errors++; $display("FAIL b2b_pulses: got %0d want 6", vt.size()); end
    if (vt.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (vt[i] != exp_t[i] || vd[i] !== exp_d[i] || vc[i] != exp_c[i]) begin
          errors++;
          $display("FAIL b2b_issue%0d: edge %0d %b,%0d want edge %0d %b,%0d",
                   i, vt[i], vd[i], vc[i], exp_t[i], exp_d[i], exp_c[i]);
        end
      end
    end
    checks++; if (issued_count !== 16'd8) begin errors++; $display("FAIL b2b_issued: got %0d want 8", issued_count); end
  endtask

  task automatic test_zero_count();
    int a, b, c;
    clear_log();
    push(1'b0, 0, a);
    push(1'b0, 0, b);
    push(1'b0, 0, c);
    wait_idle(100);
    checks++; if (vt.size() != 3) begin errors++; $display("FAIL zero_pulses: got %0d want 3", vt.size()); end
    if (vt.size() == 3) begin
      checks++; if (vt[0] != a + 2) begin errors++; $display("FAIL zero_t0: edge %0d want %0d", vt[0], a + 2); end
      checks++; if (vt[1] - vt[0] != 4) begin errors++; $display("FAIL zero_gap1: got %0d want 4", vt[1] - vt[0]); end
      checks++; if (vt[2] - vt[1] != 4) begin errors++; $display("FAIL zero_gap2: got %0d want 4", vt[2] - vt[1]); end
      checks++; if (vc[2] != 0 || vd[2] !== 1'b0) begin errors++; $display("FAIL zero_op: %b,%0d want 0,0", vd[2], vc[2]); end
    end
  endtask

  task automatic test_max_count();
    int a, b;
    clear_log();
    push(1'b1, 1023, a);
    push(1'b0, 0, b);
    wait_idle(1200);
    checks++; if (vt.size() != 2) begin errors++; $display("FAIL max_pulses: got %0d want 2", vt.size()); end
    if (vt.size() == 2) begin
      checks++; if (vt[0] != a + 2 || vc[0] != 1023 || vd[0] !== 1'b1) begin
        errors++; $display("FAIL max_first: edge %0d %b,%0d want edge %0d 1,1023", vt[0], vd[0], vc[0], a + 2);
      end
      checks++; if (vt[1] - vt[0] != 1027) begin errors++; $display("FAIL max_period: got %0d want 1027", vt[1] - vt[0]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int a, tmp;
    push(1'b1, 50, a);
    for (int i = 0; i < 3; i++) push(1'b0, i + 1, tmp);
    repeat (2) tick();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL rmw_level_before: got %0d want 3", fifo_level); end
    clear_log();
    rst_n = 1'b0;
    tick();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmw_level: got %0d want 0", fifo_level); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rmw_idle: got %b want 1", idle); end
    checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL rmw_issued: got %0d want 0", issued_count); end
    checks++; if (dial_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rmw_outputs: valid=%b ready=%b want 0/1", dial_valid, cmd_ready);
    end
    checks++; if (dial_count !== 10'd0 || dial_direction !== 1'b0) begin
      errors++; $display("FAIL rmw_operands: %b,%0d want 0,0", dial_direction, dial_count);
    end
    rst_n = 1'b1;
    repeat (100) tick();
    checks++; if (vt.size() != 0) begin errors++; $display("FAIL rmw_no_issue: got %0d pulses want 0", vt.size()); end
    checks++; if (idle !== 1'b1 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL rmw_stay_idle: idle=%b level=%0d want 1/0", idle, fifo_level);
    end
  endtask

`ifdef DIAL_SEQ_BUSY_EN
  task automatic test_busy();
    int a, b;
    clear_log();
    push(1'b1, 7, a);
    push(1'b0, 2, b);
    dial_busy = 1'b1;
    repeat (51) tick();
    dial_busy = 1'b0;
    wait_idle(100);
    checks++; if (vt.size() != 2) begin errors++; $display("FAIL busy_pulses: got %0d want 2", vt.size()); end
    if (vt.size() == 2) begin
      checks++; if (vt[0] != a + 2) begin errors++; $display("FAIL busy_t0: edge %0d want %0d", vt[0], a + 2); end
      checks++; if (vt[1] != a + 55) begin errors++; $display("FAIL busy_t1: edge %0d want %0d", vt[1], a + 55); end
    end
  endtask
`endif

  initial begin
`ifdef DIAL_SEQ_BUSY_EN
    dial_busy = 1'b0;
`endif
    test_reset();
`ifdef DIAL_SEQ_BUSY_EN
    test_busy();
`else
    test_single();
    test_back_to_back();
    test_zero_count();
    test_max_count();
    test_reset_mid_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
